// File: rtl/spi_slave_rx_fifo.sv
// SPI slave receiver: synchronizes SCK/SS/MOSI into clk, assembles MSB-first words
// and queues them in a receive FIFO with overflow, end-of-stream and framing flags.
module spi_slave_rx_fifo #(
  parameter int unsigned        DATA_W     = 8,
  parameter int unsigned        FIFO_DEPTH = 16,
  parameter bit                 CPOL       = 1'b0,
  parameter bit                 CPHA       = 1'b0,
  parameter logic [DATA_W-1:0]  TERM_VALUE = '0
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          ck_sck,
  input  logic                          ck_ss,
  input  logic                          ck_mosi,
  output logic [DATA_W-1:0]             rd_data,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  input  logic                          clr_ovf,
  output logic                          term_seen,
  output logic                          frame_err
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned BIT_W = $clog2(DATA_W + 1);

  logic sck_meta, sck_s, sck_prev;
  logic ss_meta, ss_s, ss_prev;
  logic mosi_meta, mosi_s;

  logic [DATA_W-1:0] shift;
  logic [BIT_W-1:0]  bit_cnt;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;

  logic              sck_rise_c, sck_fall_c, sample_c, ss_rise_c;
  logic              word_done_c, pop_c, full_c, push_ok_c;
  logic [DATA_W-1:0] word_c;
  logic [CNT_W-1:0]  count_nxt_c;
  logic [PTR_W-1:0]  rd_ptr_nxt_c;

  // Edge detection, word assembly and FIFO next-state
  always_comb begin
    sck_rise_c   = 1'b0;
    sck_fall_c   = 1'b0;
    sample_c     = 1'b0;
    ss_rise_c    = 1'b0;
    word_c       = '0;
    word_done_c  = 1'b0;
    pop_c        = 1'b0;
    full_c       = 1'b0;
    push_ok_c    = 1'b0;
    count_nxt_c  = fifo_count;
    rd_ptr_nxt_c = rd_ptr;

    sck_rise_c = sck_s & ~sck_prev;
    sck_fall_c = ~sck_s & sck_prev;
    // Modes 1 and 2 sample on the falling edge, modes 0 and 3 on the rising edge
    sample_c   = ~ss_s & ((CPOL ^ CPHA) ? sck_fall_c : sck_rise_c);
    ss_rise_c  = ss_s & ~ss_prev;

    word_c      = {shift[DATA_W-2:0], mosi_s};
    word_done_c = sample_c && (bit_cnt == BIT_W'(DATA_W - 1));

    pop_c     = rd_valid & rd_ready;
    full_c    = (fifo_count == CNT_W'(FIFO_DEPTH));
    push_ok_c = word_done_c & (~full_c | pop_c);

    count_nxt_c  = fifo_count + CNT_W'(push_ok_c) - CNT_W'(pop_c);
    rd_ptr_nxt_c = rd_ptr + PTR_W'(1);
  end

  // Two-flop synchronizers plus previous-value registers for edge detection
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sck_meta  <= CPOL;
      sck_s     <= CPOL;
      sck_prev  <= CPOL;
      ss_meta   <= 1'b1;
      ss_s      <= 1'b1;
      ss_prev   <= 1'b1;
      mosi_meta <= 1'b0;
      mosi_s    <= 1'b0;
    end else begin
      sck_meta  <= ck_sck;
      sck_s     <= sck_meta;
      sck_prev  <= sck_s;
      ss_meta   <= ck_ss;
      ss_s      <= ss_meta;
      ss_prev   <= ss_s;
      mosi_meta <= ck_mosi;
      mosi_s    <= mosi_meta;
    end
  end

  // Shifter, bit counter and status pulses
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      shift     <= '0;
      bit_cnt   <= '0;
      term_seen <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (sample_c) begin
        shift   <= word_c;
        bit_cnt <= word_done_c ? '0 : bit_cnt + BIT_W'(1);
      end else if (ss_rise_c) begin
        bit_cnt <= '0;
      end
      term_seen <= word_done_c && (word_c == TERM_VALUE);
      frame_err <= ss_rise_c && (bit_cnt != '0);
    end
  end

  // FIFO pointers, occupancy, registered head word and sticky overflow
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push_ok_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)     rd_ptr <= rd_ptr_nxt_c;
      fifo_count <= count_nxt_c;
      rd_valid   <= (count_nxt_c != '0);
      // When the FIFO is (or becomes) empty the incoming word bypasses straight to the head
      if ((fifo_count == '0) || (pop_c && (fifo_count == CNT_W'(1)))) begin
        if (push_ok_c) rd_data <= word_c;
      end else if (pop_c) begin
        rd_data <= mem[rd_ptr_nxt_c];
      end
      if (word_done_c && full_c && !pop_c) overflow <= 1'b1;
      else if (clr_ovf)                    overflow <= 1'b0;
    end
  end

  // Storage array needs no reset; occupancy tracking guards every read
  always_ff @(posedge clk) begin
    if (push_ok_c) mem[wr_ptr] <= word_c;
  end

endmodule

// File: tb/tb_spi_slave_rx_fifo.sv
// Directed bench for spi_slave_rx_fifo: five instances cover default config,
// a 4-deep FIFO and the three remaining SPI modes.
module tb_spi_slave_rx_fifo;

  logic       clk = 1'b0;
  logic       resetn;
  logic [4:0] sck, ss, rr, clr;
  logic       mosi;

  wire  [7:0] rd_data [5];
  wire  [4:0] rv, ovf, ts, fe;
  wire  [4:0] cnt0, cnt2, cnt3, cnt4;
  wire  [2:0] cnt1;

  int errors = 0;
  int checks = 0;
  int fe_cnt = 0;
  int ts_cnt = 0;

  always #5 clk = ~clk;

  spi_slave_rx_fifo u0 (.clk(clk), .resetn(resetn), .ck_sck(sck[0]), .ck_ss(ss[0]), .ck_mosi(mosi),
    .rd_data(rd_data[0]), .rd_valid(rv[0]), .rd_ready(rr[0]), .fifo_count(cnt0), .overflow(ovf[0]),
    .clr_ovf(clr[0]), .term_seen(ts[0]), .frame_err(fe[0]));
  spi_slave_rx_fifo #(.FIFO_DEPTH(4)) u1 (.clk(clk), .resetn(resetn), .ck_sck(sck[1]), .ck_ss(ss[1]),
    .ck_mosi(mosi), .rd_data(rd_data[1]), .rd_valid(rv[1]), .rd_ready(rr[1]), .fifo_count(cnt1),
    .overflow(ovf[1]), .clr_ovf(clr[1]), .term_seen(ts[1]), .frame_err(fe[1]));
  spi_slave_rx_fifo #(.CPOL(1'b0), .CPHA(1'b1)) u2 (.clk(clk), .resetn(resetn), .ck_sck(sck[2]),
    .ck_ss(ss[2]), .ck_mosi(mosi), .rd_data(rd_data[2]), .rd_valid(rv[2]), .rd_ready(rr[2]),
    .fifo_count(cnt2), .overflow(ovf[2]), .clr_ovf(clr[2]), .term_seen(ts[2]), .frame_err(fe[2]));
  spi_slave_rx_fifo #(.CPOL(1'b1), .CPHA(1'b0)) u3 (.clk(clk), .resetn(resetn), .ck_sck(sck[3]),
    .ck_ss(ss[3]), .ck_mosi(mosi), .rd_data(rd_data[3]), .rd_valid(rv[3]), .rd_ready(rr[3]),
    .fifo_count(cnt3), .overflow(ovf[3]), .clr_ovf(clr[3]), .term_seen(ts[3]), .frame_err(fe[3]));
  spi_slave_rx_fifo #(.CPOL(1'b1), .CPHA(1'b1)) u4 (.clk(clk), .resetn(resetn), .ck_sck(sck[4]),
    .ck_ss(ss[4]), .ck_mosi(mosi), .rd_data(rd_data[4]), .rd_valid(rv[4]), .rd_ready(rr[4]),
    .fifo_count(cnt4), .overflow(ovf[4]), .clr_ovf(clr[4]), .term_seen(ts[4]), .frame_err(fe[4]));

  // Pulse counters for the default instance
  always @(posedge clk) begin
    if (fe[0]) fe_cnt <= fe_cnt + 1;
    if (ts[0]) ts_cnt <= ts_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cnt_of(input int idx);
    case (idx)
      0:       return 32'(cnt0);
      1:       return 32'(cnt1);
      2:       return 32'(cnt2);
      3:       return 32'(cnt3);
      default: return 32'(cnt4);
    endcase
  endfunction

  // Check head then pop it with a one-cycle rd_ready
  task automatic pop_chk(input int idx, input logic [7:0] exp);
    chk($sformatf("head%0d", idx), 32'(rd_data[idx]), 32'(exp));
    rr[idx] = 1'b1;
    @(negedge clk);
    rr[idx] = 1'b0;
    @(negedge clk);
  endtask

  // SPI master in the mode of instance idx; optionally pops in the cycle the last bit is pushed
  task automatic spi_xfer(input int idx, input logic [7:0] w, input int nbits, input bit raise,
                          input bit pop_last, input logic [7:0] head_exp);
    bit cp = (idx == 3 || idx == 4);
    bit ch = (idx == 2 || idx == 4);
    ss[idx] = 1'b0;
    #40;
    for (int i = 0; i < nbits; i++) begin
      if (!ch) begin
        mosi = w[7-i];
        #40;
        sck[idx] = ~cp;
        if (pop_last && i == 7) begin
          #20;
          chk($sformatf("stream_head%0d", idx), 32'(rd_data[idx]), 32'(head_exp));
          rr[idx] = 1'b1;
          #10;
          rr[idx] = 1'b0;
          #10;
        end else begin
          #40;
        end
        sck[idx] = cp;
      end else begin
        sck[idx] = ~cp;
        mosi = w[7-i];
        #40;
        sck[idx] = cp;
        #40;
      end
    end
    #40;
    if (raise) begin
      ss[idx] = 1'b1;
      #40;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic send(input int idx, input logic [7:0] w);
    spi_xfer(idx, w, 8, 1'b1, 1'b0, 8'h00);
  endtask

  initial begin
    int fe0;
    resetn = 1'b0;
    sck    = 5'b11000;
    ss     = 5'b11111;
    rr     = '0;
    clr    = '0;
    mosi   = 1'b0;
    #1;
    chk("rst_rd_data", 32'(rd_data[0]), 32'h0);
    chk("rst_rd_valid", 32'(rv[0]), 32'h0);
    chk("rst_count", cnt_of(0), 32'h0);
    chk("rst_overflow", 32'(ovf[0]), 32'h0);
    chk("rst_term", 32'(ts[0]), 32'h0);
    chk("rst_frame_err", 32'(fe[0]), 32'h0);
    chk("rst_count_d4", cnt_of(1), 32'h0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(negedge clk);

    // Basic stream with terminator
    send(0, 8'h48);
    send(0, 8'h69);
    chk("term_before", 32'(ts_cnt), 32'd0);
    chk("count_two", cnt_of(0), 32'd2);
    send(0, 8'h00);
    chk("term_after", 32'(ts_cnt), 32'd1);
    chk("count_three", cnt_of(0), 32'd3);
    pop_chk(0, 8'h48);
    pop_chk(0, 8'h69);
    pop_chk(0, 8'h00);
    chk("drained_valid", 32'(rv[0]), 32'h0);
    chk("drained_count", cnt_of(0), 32'd0);

    // Aborted partial word, then a clean word
    spi_xfer(0, 8'hA0, 3, 1'b1, 1'b0, 8'h00);
    chk("frame_err_once", 32'(fe_cnt), 32'd1);
    chk("partial_empty", 32'(rv[0]), 32'h0);
    send(0, 8'hA5);
    chk("frame_err_still_once", 32'(fe_cnt), 32'd1);
    chk("a5_count", cnt_of(0), 32'd1);
    pop_chk(0, 8'hA5);

    // Overflow on a 4-deep FIFO
    for (int i = 1; i <= 5; i++) send(1, 8'(i));
    chk("ovf_count", cnt_of(1), 32'd4);
    chk("ovf_set", 32'(ovf[1]), 32'h1);
    clr[1] = 1'b1;
    @(negedge clk);
    clr[1] = 1'b0;
    chk("ovf_cleared", 32'(ovf[1]), 32'h0);
    for (int i = 1; i <= 4; i++) pop_chk(1, 8'(i));
    chk("ovf_drained", cnt_of(1), 32'd0);

    // Full FIFO with a pop in each push cycle
    for (int i = 0; i < 4; i++) send(1, 8'h10 + 8'(i));
    chk("full_count", cnt_of(1), 32'd4);
    spi_xfer(1, 8'h14, 8, 1'b1, 1'b1, 8'h10);
    spi_xfer(1, 8'h15, 8, 1'b1, 1'b1, 8'h11);
    spi_xfer(1, 8'h16, 8, 1'b1, 1'b1, 8'h12);
    chk("stream_count", cnt_of(1), 32'd4);
    chk("stream_no_ovf", 32'(ovf[1]), 32'h0);
    for (int i = 3; i <= 6; i++) pop_chk(1, 8'h10 + 8'(i));

    // All four SPI modes
    send(0, 8'h3C);
    send(2, 8'h3C);
    send(3, 8'h3C);
    send(4, 8'h3C);
    pop_chk(0, 8'h3C);
    pop_chk(2, 8'h3C);
    pop_chk(3, 8'h3C);
    pop_chk(4, 8'h3C);
    chk("mode_cnt3", cnt_of(3), 32'd0);

    // Reset in the middle of a word
    send(0, 8'h77);
    fe0 = fe_cnt;
    spi_xfer(0, 8'h81, 5, 1'b0, 1'b0, 8'h00);
    resetn = 1'b0;
    #1;
    chk("midrst_rd_data", 32'(rd_data[0]), 32'h0);
    chk("midrst_valid", 32'(rv[0]), 32'h0);
    chk("midrst_count", cnt_of(0), 32'h0);
    chk("midrst_ovf", 32'(ovf[0]), 32'h0);
    @(negedge clk);
    ss[0] = 1'b1;
    sck[0] = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    send(0, 8'h81);
    chk("post_rst_count", cnt_of(0), 32'd1);
    chk("post_rst_no_fe", 32'(fe_cnt - fe0), 32'd0);
    pop_chk(0, 8'h81);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
